// File: rtl/spi_arb.sv
// Two-requester arbiter in front of a single SPI master: picks an owner for each
// 16-bit transaction, launches it, and returns the response with done/err pulses.
module spi_arb #(
   parameter int STARVE_LIM = 3,
   parameter int TMO_CYC    = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inert_req,
   input  logic [15:0] inert_cmd,
   output logic        inert_gnt,
   output logic        inert_done,
   input  logic        a2d_req,
   input  logic [15:0] a2d_cmd,
   output logic        a2d_gnt,
   output logic        a2d_done,
   output logic [15:0] rd_data,
   output logic        err,
   output logic        sel,
   output logic        spi_wrt,
   output logic [15:0] spi_cmd,
   input  logic        spi_done,
   input  logic [15:0] spi_resp
);

   localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
   localparam int SW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
   localparam logic [TW-1:0] TMO_LAST   = TW'(TMO_CYC - 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

   state_t        state, state_n;
   logic [SW-1:0] starve_cnt, starve_n;
   logic [TW-1:0] tmo_cnt, tmo_n;
   logic          inert_gnt_n, a2d_gnt_n, sel_n, wrt_n;
   logic          inert_done_n, a2d_done_n, err_n;
   logic [15:0]   cmd_n, rd_n;
   logic          pick_a2d;

   // A2D wins only when it is alone or inertial has used up its consecutive-grant allowance.
   assign pick_a2d = a2d_req && (!inert_req || (starve_cnt == STARVE_MAX));

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_n      = state;
      starve_n     = starve_cnt;
      tmo_n        = tmo_cnt;
      inert_gnt_n  = inert_gnt;
      a2d_gnt_n    = a2d_gnt;
      sel_n        = sel;
      cmd_n        = spi_cmd;
      rd_n         = rd_data;
      wrt_n        = 1'b0;
      inert_done_n = 1'b0;
      a2d_done_n   = 1'b0;
      err_n        = 1'b0;

      case (state)
         IDLE: begin
            if (inert_req || a2d_req) begin
               wrt_n   = 1'b1;
               state_n = LAUNCH;
               if (pick_a2d) begin
                  a2d_gnt_n = 1'b1;
                  sel_n     = 1'b1;
                  cmd_n     = a2d_cmd;
                  starve_n  = '0;
               end else begin
                  inert_gnt_n = 1'b1;
                  sel_n       = 1'b0;
                  cmd_n       = inert_cmd;
                  if (a2d_req && (starve_cnt != STARVE_MAX))
                     starve_n = starve_cnt + 1'b1;
               end
            end
         end

         LAUNCH: begin
            tmo_n   = '0;
            state_n = WAIT;
         end

         WAIT: begin
            tmo_n = tmo_cnt + 1'b1;
            // A completion on the last allowed cycle still counts as a clean finish.
            if (spi_done) begin
               rd_n         = spi_resp;
               inert_done_n = inert_gnt;
               a2d_done_n   = a2d_gnt;
               state_n      = RESP;
            end else if (tmo_cnt == TMO_LAST) begin
               inert_done_n = inert_gnt;
               a2d_done_n   = a2d_gnt;
               err_n        = 1'b1;
               state_n      = RESP;
            end
         end

         RESP: begin
            inert_gnt_n = 1'b0;
            a2d_gnt_n   = 1'b0;
            state_n     = IDLE;
         end

         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
      if (!rst_n) begin
         state      <= IDLE;
         starve_cnt <= '0;
         tmo_cnt    <= '0;
         inert_gnt  <= 1'b0;
         a2d_gnt    <= 1'b0;
         inert_done <= 1'b0;
         a2d_done   <= 1'b0;
         err        <= 1'b0;
         sel        <= 1'b0;
         spi_wrt    <= 1'b0;
         spi_cmd    <= '0;
         rd_data    <= '0;
      end else begin
         state      <= state_n;
         starve_cnt <= starve_n;
         tmo_cnt    <= tmo_n;
         inert_gnt  <= inert_gnt_n;
         a2d_gnt    <= a2d_gnt_n;
         inert_done <= inert_done_n;
         a2d_done   <= a2d_done_n;
         err        <= err_n;
         sel        <= sel_n;
         spi_wrt    <= wrt_n;
         spi_cmd    <= cmd_n;
         rd_data    <= rd_n;
      end
   end

endmodule

// File: tb/tb_spi_arb.sv
// Self-checking bench for spi_arb: directed scenarios plus randomized transactions
// checked against a transaction-level model of arbitration, timing and response data.
module tb_spi_arb;

   localparam int STARVE_LIM = 3;
   localparam int TMO_CYC    = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        inert_req, a2d_req;
   logic [15:0] inert_cmd, a2d_cmd;
   logic        inert_gnt, inert_done, a2d_gnt, a2d_done;
   logic [15:0] rd_data;
   logic        err, sel, spi_wrt;
   logic [15:0] spi_cmd;
   logic        spi_done;
   logic [15:0] spi_resp;

   always #5 clk = ~clk;

   spi_arb #(.STARVE_LIM(STARVE_LIM), .TMO_CYC(TMO_CYC)) dut (
      .clk(clk), .rst_n(rst_n),
      .inert_req(inert_req), .inert_cmd(inert_cmd), .inert_gnt(inert_gnt), .inert_done(inert_done),
      .a2d_req(a2d_req), .a2d_cmd(a2d_cmd), .a2d_gnt(a2d_gnt), .a2d_done(a2d_done),
      .rd_data(rd_data), .err(err), .sel(sel), .spi_wrt(spi_wrt), .spi_cmd(spi_cmd),
      .spi_done(spi_done), .spi_resp(spi_resp)
   );

   logic [38:0] all_outs;
   assign all_outs = {inert_gnt, inert_done, a2d_gnt, a2d_done, err, sel, spi_wrt, spi_cmd, rd_data};

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: starvation count and last delivered response word.
   int          m_starve;
   logic [15:0] m_rd;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_launch(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (spi_wrt) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   // One full transaction from the current request levels. delay = cycles in WAIT before
   // spi_done is raised; timeout = never raise spi_done.
   task automatic service(input int delay, input bit timeout, input bit handshake,
                          input logic [15:0] resp, output bit got_a2d);
      bit          seen, exp_a2d;
      logic [15:0] exp_cmd;
      int          k;
      got_a2d = 1'b0;
      exp_a2d = a2d_req && (!inert_req || (m_starve == STARVE_LIM));
      exp_cmd = exp_a2d ? a2d_cmd : inert_cmd;
      wait_launch(seen);
      check("launch_seen", 64'(seen), 64'(1));
      if (!seen) return;
      got_a2d = a2d_gnt;
      check("grant", 64'({inert_gnt, a2d_gnt, sel, spi_cmd}),
            64'({!exp_a2d, exp_a2d, exp_a2d, exp_cmd}));
      if (exp_a2d) m_starve = 0;
      else if (a2d_req && m_starve < STARVE_LIM) m_starve++;
      // Commands change after the grant; the launched word must not follow them.
      inert_cmd = 16'($urandom);
      a2d_cmd   = 16'($urandom);
      if (!timeout) begin
         for (int i = 1; i <= delay; i++) begin
            @(negedge clk);
            check("wait_hold",
                  64'({spi_wrt, inert_done, a2d_done, err, inert_gnt, a2d_gnt, sel, spi_cmd, rd_data}),
                  64'({4'b0, !exp_a2d, exp_a2d, exp_a2d, exp_cmd, m_rd}));
         end
         spi_done = 1'b1;
         spi_resp = resp;
         @(negedge clk);
         spi_done = 1'b0;
         spi_resp = 16'($urandom);
         m_rd     = resp;
      end else begin
         k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (!(inert_done || a2d_done) && k < TMO_CYC + 4);
         // TMO_CYC full WAIT cycles follow LAUNCH, then the done cycle.
         check("tmo_latency", 64'(k), 64'(TMO_CYC + 1));
      end
      check("done", 64'({inert_done, a2d_done, err, inert_gnt, a2d_gnt, sel, rd_data}),
            64'({!exp_a2d, exp_a2d, timeout, !exp_a2d, exp_a2d, exp_a2d, m_rd}));
      if (handshake) begin
         if (exp_a2d) a2d_req = 1'b0;
         else         inert_req = 1'b0;
      end
      @(negedge clk);
      check("idle_after", 64'({inert_done, a2d_done, err, inert_gnt, a2d_gnt, spi_wrt, sel}),
            64'({6'b0, exp_a2d}));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          got, seen;
      logic [7:0]  seq;
      logic [3:0]  seq2;
      logic [15:0] r16;
      int          r;
      bit          wrt_seen;

      rst_n = 1'b0; inert_req = 1'b0; a2d_req = 1'b0;
      inert_cmd = '0; a2d_cmd = '0; spi_done = 1'b0; spi_resp = '0;
      m_starve = 0; m_rd = '0;
      repeat (2) @(negedge clk);
      check("reset_outputs", 64'(all_outs), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_no_req", 64'(all_outs), 64'(0));

      // Inertial alone.
      inert_req = 1'b1;
      inert_cmd = 16'hA5A5;
      service(12, 1'b0, 1'b1, 16'h1234, got);
      check("inert_owner", 64'(got), 64'(0));
      check("inert_rd", 64'(rd_data), 64'(16'h1234));

      // A2D alone.
      a2d_req = 1'b1;
      a2d_cmd = 16'h0C00;
      r16 = 16'($urandom);
      service(7, 1'b0, 1'b1, r16, got);
      check("a2d_owner", 64'(got), 64'(1));

      // Stray spi_done while idle.
      spi_done = 1'b1;
      spi_resp = 16'hFFFF;
      @(negedge clk);
      spi_done = 1'b0;
      check("stray_done", 64'({inert_gnt, inert_done, a2d_gnt, a2d_done, err, spi_wrt, rd_data}),
            64'({6'b0, m_rd}));
      check("stray_sel_hold", 64'(sel), 64'(1));
      wrt_seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         wrt_seen = wrt_seen | spi_wrt;
      end
      check("stray_no_launch", 64'(wrt_seen), 64'(0));

      // Timeout, then a normal transaction afterwards.
      inert_req = 1'b1;
      inert_cmd = 16'($urandom);
      service(0, 1'b1, 1'b1, 16'h0000, got);
      a2d_req = 1'b1;
      service(5, 1'b0, 1'b1, 16'h5A3C, got);
      check("post_tmo_rd", 64'(rd_data), 64'(16'h5A3C));

      // spi_done on the last allowed cycle beats the timeout.
      inert_req = 1'b1;
      service(TMO_CYC, 1'b0, 1'b1, 16'hBEEF, got);

      // Both held continuously: I,I,I,A,I,I,I,A.
      inert_req = 1'b1;
      a2d_req   = 1'b1;
      seq = '0;
      for (int i = 0; i < 8; i++) begin
         service(int'($urandom_range(1, 8)), 1'b0, 1'b0, 16'($urandom), got);
         seq[i] = got;
      end
      check("starve_seq", 64'(seq), 64'(8'h88));

      // Two more inertial grants, then reset in WAIT of the third.
      service(3, 1'b0, 1'b0, 16'($urandom), got);
      service(3, 1'b0, 1'b0, 16'($urandom), got);
      wait_launch(seen);
      check("pre_reset_launch", 64'({seen, inert_gnt, a2d_gnt}), 64'(3'b110));
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("reset_mid_wait", 64'(all_outs), 64'(0));
      @(negedge clk);
      check("reset_no_done", 64'(all_outs), 64'(0));
      rst_n = 1'b1;
      m_starve = 0;
      m_rd = '0;
      seq2 = '0;
      for (int i = 0; i < 4; i++) begin
         service(2, 1'b0, 1'b0, 16'($urandom), got);
         seq2[i] = got;
      end
      check("post_reset_seq", 64'(seq2), 64'(4'b1000));
      inert_req = 1'b0;
      a2d_req   = 1'b0;
      @(negedge clk);

      // Randomized transactions with the done/req handshake.
      for (int n = 0; n < 40; n++) begin
         r = int'($urandom_range(1, 3));
         inert_req = r[0];
         a2d_req   = r[1];
         inert_cmd = 16'($urandom);
         a2d_cmd   = 16'($urandom);
         service(int'($urandom_range(1, TMO_CYC)), ($urandom_range(0, 4) == 0), 1'b1,
                 16'($urandom), got);
         inert_req = 1'b0;
         a2d_req   = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
